// File: rtl/bit_position_enumerator_pkg.sv
// Shared types and width helpers for bit_position_enumerator.
package bit_position_enumerator_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int idx_w(input int width);
    return $clog2(width);
  endfunction

  // Count must be able to hold WIDTH itself (all-ones word).
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/set_bit_encoder.sv
// Combinational first-set-bit encoder with a single-bit-set flag.
module set_bit_encoder #(
  parameter int WIDTH     = 24,
  parameter bit MSB_FIRST = 1'b0,
  parameter int IW        = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask_i,
  output logic [IW-1:0]    idx_o,
  output logic             one_o
);

  // Scan away from the wanted end so the wanted bit is the last write.
  always_comb begin
    idx_o = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (mask_i[i]) idx_o = IW'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (mask_i[i]) idx_o = IW'(i);
    end
  end

  assign one_o = (mask_i != '0) && ((mask_i & (mask_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/bit_position_enumerator.sv
// Streams the set-bit positions of each accepted word, then pulses done with the count.
// Define BIT_POSITION_ENUMERATOR_MSB_FIRST_EN to emit highest index first.
module bit_position_enumerator
  import bit_position_enumerator_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [WIDTH-1:0]          data_i,
  input  logic                      data_val_i,
  output logic                      data_ready_o,
  output logic [idx_w(WIDTH)-1:0]   idx_o,
  output logic                      idx_val_o,
  output logic                      idx_last_o,
  input  logic                      idx_ready_i,
  output logic                      done_o,
  output logic [cnt_w(WIDTH)-1:0]   count_o
);

  localparam int IW = idx_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);
`ifdef BIT_POSITION_ENUMERATOR_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    enc_idx;
  logic             enc_one;

  set_bit_encoder #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .IW        (IW)
  ) u_enc (
    .mask_i (mask_q),
    .idx_o  (enc_idx),
    .one_o  (enc_one)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from state so reset clears them without a clock.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    data_ready_o = 1'b0;
    idx_val_o    = 1'b0;
    idx_last_o   = 1'b0;
    idx_o        = '0;
    done_o       = 1'b0;
    count_o      = '0;
    case (state_q)
      S_IDLE: begin
        data_ready_o = 1'b1;
        if (data_val_i) begin
          mask_d  = data_i;
          cnt_d   = '0;
          state_d = (data_i != '0) ? S_EMIT : S_DONE;
        end
      end
      S_EMIT: begin
        idx_val_o  = 1'b1;
        idx_o      = enc_idx;
        idx_last_o = enc_one;
        if (idx_ready_i) begin
          mask_d[enc_idx] = 1'b0;
          cnt_d           = cnt_q + CW'(1);
          if (enc_one) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        count_o = cnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bit_position_enumerator.sv
// Self-checking bench: directed vector table, reset corner, and random words vs a queue model.
module tb_bit_position_enumerator;

  localparam int WIDTH = 24;
`ifdef BIT_POSITION_ENUMERATOR_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic [WIDTH-1:0] data_i;
  logic             data_val_i;
  logic             data_ready_o;
  logic [4:0]       idx_o;
  logic             idx_val_o;
  logic             idx_last_o;
  logic             idx_ready_i;
  logic             done_o;
  logic [4:0]       count_o;

  int n_total = 0;
  int n_pass  = 0;

  bit_position_enumerator #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .data_i       (data_i),
    .data_val_i   (data_val_i),
    .data_ready_o (data_ready_o),
    .idx_o        (idx_o),
    .idx_val_o    (idx_val_o),
    .idx_last_o   (idx_last_o),
    .idx_ready_i  (idx_ready_i),
    .done_o       (done_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  typedef struct {
    logic [WIDTH-1:0] data;
    int               stall;
    int               exp_count;
    int               exp_first;
    int               exp_last;
  } vec_t;

  // Runs one word through the DUT, checking every cycle against the model queue.
  task automatic run_word(input logic [WIDTH-1:0] d, input int stall_first, input bit rnd,
                          output int obs_first, output int obs_last, output int obs_count);
    int q[$];
    int k, stalls, n;
    bit rdy;
    q = {};
    for (int i = 0; i < WIDTH; i++) begin
      int b;
      b = MSB ? (WIDTH - 1 - i) : i;
      if ((d >> b) & 1) q.push_back(b);
    end
    obs_first = -1; obs_last = -1; obs_count = -1;
    n = 0;
    while (!data_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    data_i = d; data_val_i = 1'b1; idx_ready_i = 1'b1;
    @(posedge clk_i); #1;
    data_val_i = 1'b0;
    k = 0; stalls = stall_first; n = 0;
    while (k < q.size() && n < 200) begin
      if (k == 0 && stalls > 0) begin rdy = 1'b0; stalls--; end
      else rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      idx_ready_i = rdy;
      // Upstream noise while busy must be ignored.
      if (rnd) begin data_val_i = $urandom_range(0, 1); data_i = WIDTH'($urandom); end
      @(negedge clk_i);
      check("beat_val", idx_val_o, 1);
      check("beat_idx", idx_o, q[k]);
      check("beat_last", idx_last_o, (k == q.size() - 1));
      check("beat_busy", {data_ready_o, done_o}, 2'b00);
      if (k == 0) obs_first = idx_o;
      if (idx_last_o) obs_last = idx_o;
      @(posedge clk_i); #1;
      if (rdy) k++;
      n++;
    end
    if (n >= 200) check("beat_timeout", n, 0);
    data_val_i = 1'b0;
    idx_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk_i);
    check("done_pulse", done_o, 1);
    check("done_count", count_o, q.size());
    check("done_noval", idx_val_o, 0);
    obs_count = count_o;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("back_idle", {data_ready_o, done_o, idx_val_o}, 3'b100);
  endtask

  vec_t vecs[4];

  initial begin
    int f, l, c;
    rst_n_i = 1'b0; data_i = '0; data_val_i = 1'b0; idx_ready_i = 1'b0;
    #2;
    check("rst_outputs", {data_ready_o, idx_val_o, idx_last_o, done_o, idx_o, count_o}, {4'b1000, 10'd0});
    @(posedge clk_i); #3; rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    vecs[0] = '{24'h000000, 0, 0, -1, -1};
    vecs[1] = '{24'h800005, 0, 3, MSB ? 23 : 0, MSB ? 0 : 23};
    vecs[2] = '{24'hFFFFFF, 0, 24, MSB ? 23 : 0, MSB ? 0 : 23};
    vecs[3] = '{24'h000110, 3, 2, MSB ? 8 : 4, MSB ? 4 : 8};
    foreach (vecs[i]) begin
      run_word(vecs[i].data, vecs[i].stall, 1'b0, f, l, c);
      check("vec_count", c, vecs[i].exp_count);
      check("vec_first", f, vecs[i].exp_first);
      check("vec_last", l, vecs[i].exp_last);
    end

    // Async reset mid-EMIT: outputs clear at once, no done pulse.
    data_i = 24'h800005; data_val_i = 1'b1; idx_ready_i = 1'b1;
    @(posedge clk_i); #1; data_val_i = 1'b0;
    @(posedge clk_i); #3;
    check("pre_rst_val", idx_val_o, 1);
    rst_n_i = 1'b0; #1;
    check("async_rst", {data_ready_o, idx_val_o, idx_last_o, done_o, idx_o, count_o}, {4'b1000, 10'd0});
    @(posedge clk_i); #1;
    check("rst_no_done", done_o, 0);
    #2; rst_n_i = 1'b1;
    run_word(24'h000001, 0, 1'b0, f, l, c);
    check("post_rst_idx", f, 0);
    check("post_rst_count", c, 1);

    for (int t = 0; t < 40; t++) begin
      logic [WIDTH-1:0] d;
      d = WIDTH'($urandom);
      if (t % 3 == 0) d = d & WIDTH'($urandom) & WIDTH'($urandom);
      run_word(d, 0, 1'b1, f, l, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bit_position_enumerator.md
BIT_POSITION_ENUMERATOR -- requirements
Module: bit_position_enumerator

Interface
REQ-001 SHALL have parameter WIDTH, default 24: input word width in bits, 2..256, not required to be a power of two.
REQ-002 SHALL have clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n_i  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have data_i  input  WIDTH  word whose set-bit positions are enumerated.
REQ-005 SHALL have data_val_i  input  1  data_i valid.
REQ-006 SHALL have data_ready_o  output  1  block can accept a word.
REQ-007 SHALL have idx_o  output  $clog2(WIDTH)  bit position of the current set bit.
REQ-008 SHALL have idx_val_o  output  1  idx_o valid.
REQ-009 SHALL have idx_last_o  output  1  current index is the final index of the word.
REQ-010 SHALL have idx_ready_i  input  1  downstream accepts idx_o.
REQ-011 SHALL have done_o  output  1  one-cycle word-complete pulse.
REQ-012 SHALL have count_o  output  $clog2(WIDTH+1)  number of indices emitted for the word; valid only with done_o.

Function
REQ-013 SHALL implement FSM states IDLE, EMIT, DONE.
REQ-014 IDLE: data_ready_o=1, idx_val_o=0, done_o=0.
REQ-015 Word accepted when data_val_i && data_ready_o at a clock edge; data_i latched into a pending-mask register and count cleared.
REQ-016 IDLE with accepted word: next state EMIT if word nonzero, DONE if zero.
REQ-017 EMIT: data_ready_o=0, idx_val_o=1, idx_o = position of lowest set bit of pending mask.
REQ-018 EMIT: idx_last_o=1 exactly when the pending mask has one bit set.
REQ-019 Index transfer when idx_val_o && idx_ready_i: clear that bit in the mask and increment count; if idx_last_o, next state DONE.
REQ-020 While idx_ready_i=0, idx_o, idx_last_o and idx_val_o SHALL hold stable.
REQ-021 DONE: done_o=1 and count_o = count for exactly one cycle, with no backpressure; next state IDLE.
REQ-022 Latency: first idx_val_o in the cycle after acceptance; a word with P set bits and no stalls occupies P+2 cycles from acceptance to return to IDLE.
REQ-023 Zero word: no index beat; done_o with count_o=0 in the cycle after acceptance.
REQ-024 All-ones word: WIDTH beats, count_o=WIDTH; the count register SHALL not overflow.
REQ-025 data_val_i while not ready SHALL be ignored; the upstream holds the word.

Reset
REQ-026 rst_n_i low SHALL force IDLE, clear mask and count, and drive idx_val_o=0, idx_last_o=0, done_o=0, idx_o=0, count_o=0 immediately, without waiting for a clock edge.
REQ-027 data_ready_o SHALL be 1 while in reset, and a word or index handshake in progress SHALL be discarded without a done_o pulse.
REQ-028 The first acceptance SHALL occur no earlier than the first rising edge after rst_n_i deasserts.

Configuration
REQ-029 Macro BIT_POSITION_ENUMERATOR_MSB_FIRST_EN: when defined, indices SHALL be emitted highest-first.
REQ-030 When BIT_POSITION_ENUMERATOR_MSB_FIRST_EN is defined, idx_last_o SHALL mark the lowest set bit.
REQ-031 When BIT_POSITION_ENUMERATOR_MSB_FIRST_EN is undefined, indices SHALL be emitted lowest-first, per REQ-017.
REQ-032 All other behaviour, including count and latency, SHALL be identical with or without the macro.

Structure
REQ-033 Package bit_position_enumerator_pkg SHALL hold the FSM state enum typedef.
REQ-034 Package bit_position_enumerator_pkg SHALL hold width-helper functions for idx and count widths.
REQ-035 Sub-module set_bit_encoder SHALL be combinational, taking the mask and returning the first-set-bit index and a single-bit-set flag, parameterised on WIDTH and search direction.

Verification (WIDTH=24)
REQ-036 data_i=24'h000000 accepted -> no idx_val_o; done_o=1, count_o=0 the next cycle.
REQ-037 data_i=24'h800005, idx_ready_i=1 -> idx_o 0, 2, 23 on consecutive cycles, idx_last_o on 23; then done_o with count_o=3; 5 cycles total.
REQ-038 data_i=24'hFFFFFF -> 24 beats with idx 0..23 and last on 23; count_o=24.
REQ-039 data_i=24'h000110 with idx_ready_i low 3 cycles on the first beat -> idx_o=4 held stable for those cycles, then 8 with last; count_o=2.
REQ-040 rst_n_i pulsed low mid-EMIT, asynchronously to clk_i -> outputs clear at once with no done_o; next word 24'h000001 -> idx_o 0, count_o=1.
REQ-041 With BIT_POSITION_ENUMERATOR_MSB_FIRST_EN defined, data_i=24'h800005 -> idx_o 23, 2, 0 with last on 0; count_o=3.
